// File: rtl/i2c_master_sda_pkg.sv
// Shared I2C master state encodings, used by the sequencing FSM and by the
// SDA datapath (i2c_master_sda). Nothing else should redefine these values.
package i2c_master_sda_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_ADDR  = 3'd2,
        ST_RW    = 3'd3,
        ST_ACK   = 3'd4,
        ST_MEM   = 3'd5,
        ST_DATA  = 3'd6,
        ST_STOP  = 3'd7
    } state_t;

    localparam int unsigned BYTE_BITS = 8;
    localparam int unsigned LAST_ACK  = 3;

    // Bit phases drive a data bit onto SDA and advance the shift register.
    function automatic logic is_bit_phase(input state_t s);
        return (s == ST_ADDR) || (s == ST_RW) || (s == ST_MEM) || (s == ST_DATA);
    endfunction

endpackage

// File: rtl/i2c_master_sda_tx_shifter.sv
// i2c_tx_shifter: 8-bit load/shift-left register, MSB presented on msb.
// Ports:
//   scl_clk  - clock (rising edge)
//   reset    - synchronous active-high clear
//   load     - load din (wins over shift)
//   din[7:0] - parallel load value
//   shift    - shift left by one, zero fill
//   msb      - current bit 7
module i2c_tx_shifter (
    input  logic       scl_clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] din,
    input  logic       shift,
    output logic       msb
);

    logic [7:0] shreg;

    always_ff @(posedge scl_clk) begin
        if (reset) begin
            shreg <= 8'h00;
        end else if (load) begin
            shreg <= din;
        end else if (shift) begin
            shreg <= {shreg[6:0], 1'b0};
        end
    end

    assign msb = shreg[7];

endmodule

// File: rtl/i2c_master_sda.sv
// i2c_master_sda: SDA datapath for an I2C master write frame
// (address+RW, register address, data byte). The external FSM owns the
// sequencing; this block serialises bytes, samples ACKs and reports errors.
// Ports:
//   scl_clk, reset       - clock, synchronous active-high reset
//   state[2:0]           - current FSM state (state_t encoding)
//   start                - start strobe; operands sampled with it in IDLE
//   dev_addr, rw         - 7-bit slave address and R/W bit
//   mem_addr, wr_data    - register address byte and data byte
//   sda_in               - sampled SDA line
//   sda_oe               - 1 pulls SDA low, 0 releases it
//   busy                 - state != IDLE
//   ack_err[2:0]         - sticky NACK flags (addr, mem, data)
//   frame_err            - sticky bit-count / phase violation flag
//   done                 - one-cycle pulse after a STOP edge
module i2c_master_sda
    import i2c_master_sda_pkg::*;
#(
    parameter bit ACK_CHECK = 1'b1
) (
    input  logic       scl_clk,
    input  logic       reset,
    input  logic [2:0] state,
    input  logic       start,
    input  logic [6:0] dev_addr,
    input  logic       rw,
    input  logic [7:0] mem_addr,
    input  logic [7:0] wr_data,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic       busy,
    output logic [2:0] ack_err,
    output logic       frame_err,
    output logic       done
);

    state_t     st;
    state_t     prev_state;
    logic       capture;
    logic       shift_en;
    logic       ack_edge;
    logic       stop_edge;
    logic       illegal;
    logic       load;
    logic [7:0] din;
    logic       msb;
    logic [2:0] nack_mask;
    logic [3:0] bit_cnt;
    logic [1:0] ack_idx;
    logic [7:0] mem_q;
    logic [7:0] data_q;

    assign st = state_t'(state);

    always_comb begin
        capture   = (st == ST_IDLE) && start;
        shift_en  = is_bit_phase(st);
        ack_edge  = (st == ST_ACK);
        stop_edge = (st == ST_STOP);
        // Only START may follow IDLE; anything else means the FSM skipped a phase.
        illegal   = (prev_state == ST_IDLE) && (st != ST_IDLE) && (st != ST_START);
        nack_mask = (ACK_CHECK && sda_in) ? (3'b001 << ack_idx) : 3'b000;

        load = 1'b0;
        din  = 8'h00;
        if (capture) begin
            load = 1'b1;
            din  = {dev_addr, rw};
        end else if (ack_edge && (ack_idx == 2'd0)) begin
            load = 1'b1;
            din  = mem_q;
        end else if (ack_edge && (ack_idx == 2'd1)) begin
            load = 1'b1;
            din  = data_q;
        end
    end

    i2c_tx_shifter u_shifter (
        .scl_clk (scl_clk),
        .reset   (reset),
        .load    (load),
        .din     (din),
        .shift   (shift_en),
        .msb     (msb)
    );

    always_comb begin
        sda_oe = 1'b0;
        case (st)
            ST_IDLE:  sda_oe = 1'b0;
            ST_START: sda_oe = 1'b1;
            ST_ACK:   sda_oe = 1'b0;
            ST_STOP:  sda_oe = 1'b1;
            default:  sda_oe = ~msb;
        endcase
    end

    assign busy = (st != ST_IDLE);

    always_ff @(posedge scl_clk) begin
        if (reset) begin
            bit_cnt    <= 4'd0;
            ack_idx    <= 2'd0;
            ack_err    <= 3'b000;
            frame_err  <= 1'b0;
            done       <= 1'b0;
            mem_q      <= 8'h00;
            data_q     <= 8'h00;
            prev_state <= ST_IDLE;
        end else begin
            prev_state <= st;
            done       <= stop_edge;
            if (capture) begin
                // Later bytes are latched here so pin changes mid-frame are ignored.
                bit_cnt   <= 4'd0;
                ack_idx   <= 2'd0;
                ack_err   <= 3'b000;
                frame_err <= 1'b0;
                mem_q     <= mem_addr;
                data_q    <= wr_data;
            end else begin
                if (shift_en) begin
                    bit_cnt <= bit_cnt + 4'd1;
                end
                if (ack_edge) begin
                    ack_err <= ack_err | nack_mask;
                    if ((bit_cnt != 4'(BYTE_BITS)) || (ack_idx == 2'(LAST_ACK))) begin
                        frame_err <= 1'b1;
                    end
                    bit_cnt <= 4'd0;
                    if (ack_idx != 2'(LAST_ACK)) begin
                        ack_idx <= ack_idx + 2'd1;
                    end
                end
                if (stop_edge && (ack_idx != 2'(LAST_ACK))) begin
                    frame_err <= 1'b1;
                end
                if (illegal) begin
                    frame_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_i2c_master_sda.sv
module tb_i2c_master_sda;
    import i2c_master_sda_pkg::*;

    logic       scl_clk = 1'b0;
    logic       reset;
    logic [2:0] state;
    logic       start;
    logic [6:0] dev_addr;
    logic       rw;
    logic [7:0] mem_addr;
    logic [7:0] wr_data;
    logic       sda_in;

    logic       oe0, busy0, ferr0, done0;
    logic [2:0] aerr0;
    logic       oe1, busy1, ferr1, done1;
    logic [2:0] aerr1;

    int n_checks = 0;
    int n_fail   = 0;

    i2c_master_sda #(.ACK_CHECK(1'b1)) dut (
        .scl_clk(scl_clk), .reset(reset), .state(state), .start(start),
        .dev_addr(dev_addr), .rw(rw), .mem_addr(mem_addr), .wr_data(wr_data),
        .sda_in(sda_in), .sda_oe(oe0), .busy(busy0), .ack_err(aerr0),
        .frame_err(ferr0), .done(done0)
    );

    i2c_master_sda #(.ACK_CHECK(1'b0)) dut_nochk (
        .scl_clk(scl_clk), .reset(reset), .state(state), .start(start),
        .dev_addr(dev_addr), .rw(rw), .mem_addr(mem_addr), .wr_data(wr_data),
        .sda_in(sda_in), .sda_oe(oe1), .busy(busy1), .ack_err(aerr1),
        .frame_err(ferr1), .done(done1)
    );

    always #5 scl_clk = ~scl_clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic bitcyc(input state_t s, input logic exp_oe, input string tag);
        @(negedge scl_clk);
        state = s; start = 1'b0; sda_in = 1'b1;
        #1;
        check(tag, 8'(oe0), 8'(exp_oe));
        @(posedge scl_clk);
    endtask

    task automatic ackcyc(input logic nack, input string tag);
        @(negedge scl_clk);
        state = ST_ACK; start = 1'b0; sda_in = nack;
        #1;
        check(tag, 8'(oe0), 8'h00);
        @(posedge scl_clk);
    endtask

    task automatic send_byte(input state_t s, input logic [7:0] b, input string tag);
        for (int i = 0; i < 8; i++) begin
            bitcyc(s, ~b[7-i], tag);
        end
    endtask

    // Capture, START (with conflicting pins and start held to prove no recapture), address+RW, ACK0.
    task automatic frame_head(input logic [6:0] da, input logic r, input logic [7:0] ma,
                              input logic [7:0] wd, input logic nack0);
        logic [7:0] ab;
        ab = {da, r};
        @(negedge scl_clk);
        state = ST_IDLE; start = 1'b1; dev_addr = da; rw = r; mem_addr = ma; wr_data = wd; sda_in = 1'b0;
        #1;
        check("idle_oe", 8'(oe0), 8'h00);
        check("idle_busy", 8'(busy0), 8'h00);
        @(posedge scl_clk);
        @(negedge scl_clk);
        state = ST_START; start = 1'b1; dev_addr = ~da; rw = ~r; mem_addr = ~ma; wr_data = ~wd;
        #1;
        check("start_oe", 8'(oe0), 8'h01);
        check("start_busy", 8'(busy0), 8'h01);
        check("capture_ack_err", 8'(aerr0), 8'h00);
        check("capture_frame_err", 8'(ferr0), 8'h00);
        @(posedge scl_clk);
        for (int i = 0; i < 7; i++) begin
            bitcyc(ST_ADDR, ~ab[7-i], "addr_oe");
        end
        bitcyc(ST_RW, ~ab[0], "rw_oe");
        ackcyc(nack0, "ack0_oe");
    endtask

    task automatic run_frame(input logic [6:0] da, input logic r, input logic [7:0] ma,
                             input logic [7:0] wd, input logic [2:0] nack, input logic [2:0] exp_err);
        frame_head(da, r, ma, wd, nack[0]);
        send_byte(ST_MEM, ma, "mem_oe");
        ackcyc(nack[1], "ack1_oe");
        send_byte(ST_DATA, wd, "data_oe");
        ackcyc(nack[2], "ack2_oe");
        bitcyc(ST_STOP, 1'b1, "stop_oe");
        @(negedge scl_clk);
        state = ST_IDLE;
        #1;
        check("done_pulse", 8'(done0), 8'h01);
        check("done_pulse_nochk", 8'(done1), 8'h01);
        check("end_oe", 8'(oe0), 8'h00);
        check("end_busy", 8'(busy0), 8'h00);
        check("end_ack_err", 8'(aerr0), 8'(exp_err));
        check("end_ack_err_nochk", 8'(aerr1), 8'h00);
        check("end_frame_err", 8'(ferr0), 8'h00);
        @(posedge scl_clk);
        @(negedge scl_clk);
        #1;
        check("done_one_cycle", 8'(done0), 8'h00);
        check("hold_ack_err", 8'(aerr0), 8'(exp_err));
        check("hold_frame_err", 8'(ferr0), 8'h00);
        @(posedge scl_clk);
    endtask

    initial begin
        reset = 1'b1; state = ST_IDLE; start = 1'b0; dev_addr = 7'h00; rw = 1'b0;
        mem_addr = 8'h00; wr_data = 8'h00; sda_in = 1'b1;
        repeat (2) @(posedge scl_clk);
        @(negedge scl_clk);
        reset = 1'b0;
        #1;
        check("rst_oe", 8'(oe0), 8'h00);
        check("rst_busy", 8'(busy0), 8'h00);
        check("rst_ack_err", 8'(aerr0), 8'h00);
        check("rst_frame_err", 8'(ferr0), 8'h00);
        check("rst_done", 8'(done0), 8'h00);

        // Clean write frame
        run_frame(7'h50, 1'b0, 8'hA5, 8'h3C, 3'b000, 3'b000);
        // NACK on mem ACK only
        run_frame(7'h50, 1'b0, 8'hA5, 8'h3C, 3'b010, 3'b010);
        // Next frame clears flags at capture; new operands
        run_frame(7'h7F, 1'b1, 8'hFF, 8'h00, 3'b000, 3'b000);
        // NACK on address and data ACKs
        run_frame(7'h2A, 1'b1, 8'h81, 8'h7E, 3'b101, 3'b101);

        // Reset in 4th MEM cycle after an address NACK
        frame_head(7'h50, 1'b0, 8'hA5, 8'h3C, 1'b1);
        bitcyc(ST_MEM, 1'b0, "abort_mem_oe");
        check("abort_pre_ack_err", 8'(aerr0), 8'h01);
        bitcyc(ST_MEM, 1'b1, "abort_mem_oe");
        bitcyc(ST_MEM, 1'b0, "abort_mem_oe");
        @(negedge scl_clk);
        state = ST_MEM; reset = 1'b1;
        @(posedge scl_clk);
        @(negedge scl_clk);
        reset = 1'b0; state = ST_IDLE;
        #1;
        check("abort_oe", 8'(oe0), 8'h00);
        check("abort_ack_err", 8'(aerr0), 8'h00);
        check("abort_frame_err", 8'(ferr0), 8'h00);
        check("abort_done", 8'(done0), 8'h00);
        check("abort_busy", 8'(busy0), 8'h00);
        @(posedge scl_clk);
        @(negedge scl_clk);
        #1;
        check("abort_done_later", 8'(done0), 8'h00);

        // Forced IDLE -> MEM
        check("skip_pre_frame_err", 8'(ferr0), 8'h00);
        @(negedge scl_clk);
        state = ST_MEM;
        @(posedge scl_clk);
        @(negedge scl_clk);
        state = ST_IDLE;
        #1;
        check("skip_frame_err", 8'(ferr0), 8'h01);
        check("skip_done", 8'(done0), 8'h00);
        @(posedge scl_clk);

        // ACK after only 6 address bits
        @(negedge scl_clk);
        state = ST_IDLE; start = 1'b1; dev_addr = 7'h50; rw = 1'b0; mem_addr = 8'hA5; wr_data = 8'h3C; sda_in = 1'b0;
        @(posedge scl_clk);
        @(negedge scl_clk);
        state = ST_START; start = 1'b0;
        #1;
        check("short_capture_frame_err", 8'(ferr0), 8'h00);
        @(posedge scl_clk);
        for (int i = 0; i < 6; i++) begin
            bitcyc(ST_ADDR, ~(8'hA0 >> (7 - i)) & 1'b1, "short_addr_oe");
        end
        ackcyc(1'b0, "short_ack_oe");
        @(negedge scl_clk);
        state = ST_IDLE;
        #1;
        check("short_frame_err", 8'(ferr0), 8'h01);
        check("short_ack_err", 8'(aerr0), 8'h00);
        @(posedge scl_clk);

        // Capture clears frame_err; clean frame afterwards
        run_frame(7'h50, 1'b0, 8'hA5, 8'h3C, 3'b000, 3'b000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
